// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2,
        FAULT   = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - instruction memory and decode-side signals of the fetch unit
interface fetch_if;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        i_stall;
    logic        i_pc_sel;
    logic [31:0] i_alu_data;
    logic        o_instr_vld;
    logic [31:0] o_instr;
    logic [31:0] o_pc;

    // fetch unit side
    modport master (
        output o_imem_req, o_imem_addr, o_instr_vld, o_instr, o_pc,
        input  i_imem_rvalid, i_imem_rdata, i_stall, i_pc_sel, i_alu_data
    );

    // memory / decode side
    modport slave (
        input  o_imem_req, o_imem_addr, o_instr_vld, o_instr, o_pc,
        output i_imem_rvalid, i_imem_rdata, i_stall, i_pc_sel, i_alu_data
    );
endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO of {pc, instr} entries; clear beats push/pop
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output fetch_entry_t     head,
    output logic             full,
    output logic             empty
);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // next pointers, count and storage; a pop frees the slot a full push needs
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // FIFO state registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // a response is only requested when a slot will be free for it
    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(push && !clear && full && !pop));

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner, instruction memory requester and decode feeder (optional FETCH_MISALIGN_CHK_EN)
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic    i_clk,
    input  logic    i_rst_n,
    fetch_if.master bus
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic    o_fetch_fault
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic [31:0]      target;
    logic             imem_req;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_clear;
    fetch_entry_t     push_entry;
    fetch_entry_t     fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] post_count;
    logic             fifo_full;
    logic             fifo_empty;

`ifdef FETCH_MISALIGN_CHK_EN
    assign target        = bus.i_alu_data;
    assign o_fetch_fault = (state_q == FAULT);
`else
    assign target        = bus.i_alu_data & 32'hFFFF_FFFC;
`endif

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .clear     (fifo_clear),
        .count     (fifo_count),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // next state, PC and request; a redirect overrides everything else
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        imem_req   = 1'b0;
        fifo_push  = 1'b0;
        fifo_clear = 1'b0;
        push_entry = '{pc: req_pc_q, instr: bus.i_imem_rdata};
        fifo_pop   = !fifo_empty && !bus.i_stall && !bus.i_pc_sel;
        post_count = fifo_count + CNT_W'(1) - CNT_W'(fifo_pop);
        if (bus.i_pc_sel) begin
            pc_d       = target;
            fifo_clear = 1'b1;
            case (state_q)
                WAIT:    state_d = bus.i_imem_rvalid ? IDLE : DISCARD;
                FAULT:   state_d = IDLE;
                default: state_d = state_q;
            endcase
`ifdef FETCH_MISALIGN_CHK_EN
            if (bus.i_alu_data[1:0] != 2'b00) begin
                state_d = FAULT;
            end
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_rst_n && !fifo_full) begin
                        imem_req = 1'b1;
                        req_pc_d = pc_q;
                        pc_d     = pc_q + 32'd4;
                        state_d  = WAIT;
                    end
                end
                WAIT: begin
                    if (bus.i_imem_rvalid) begin
                        fifo_push = 1'b1;
                        if (post_count < CNT_W'(DEPTH)) begin
                            imem_req = 1'b1;
                            req_pc_d = pc_q;
                            pc_d     = pc_q + 32'd4;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                DISCARD: begin
                    if (bus.i_imem_rvalid) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // state, PC and in-flight request PC registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    assign bus.o_imem_req  = imem_req;
    assign bus.o_imem_addr = pc_q;
    assign bus.o_instr_vld = !fifo_empty;
    assign bus.o_instr     = fifo_empty ? NOP_INSTR : fifo_head.instr;
    assign bus.o_pc        = fifo_empty ? 32'h0 : fifo_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with a memory responder and decode-order model
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RPC   = 32'h0000_0100;
    localparam int          DEPTH = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_if bus_if ();
`ifdef FETCH_MISALIGN_CHK_EN
    logic fault_o;
`endif

    fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_if)
`ifdef FETCH_MISALIGN_CHK_EN
        ,
        .o_fetch_fault (fault_o)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    exp_t        exp_q[$];
    logic [31:0] m_pc;
    bit          m_fault;
    bit          outst;
    bit          stale;
    logic [31:0] out_addr;
    int          due;
    int          lat;
    logic [31:0] req_log[$];
    int          req_cyc[$];
    int          first_vld_cyc;
    logic [31:0] pc_at_c2;
    bit          seen_10c;
    logic [31:0] s_pc;
    logic        s_vld;
    logic        s_fault;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // compare DUT outputs with the model for this cycle, then advance the model
    task automatic compare_cycle(input bit stall, input bit sel, input logic [31:0] alu, input bit rv);
        bit vld_e, pop, accept, req_e;
        int sz;
        sz    = exp_q.size();
        vld_e = (sz > 0);
        check1("instr_vld", bus_if.o_instr_vld, vld_e);
        if (vld_e) begin
            check32("o_pc", bus_if.o_pc, exp_q[0].pc);
            check32("o_instr", bus_if.o_instr, exp_q[0].instr);
        end else begin
            check32("o_pc_empty", bus_if.o_pc, 32'h0);
            check32("o_instr_empty", bus_if.o_instr, NOP_INSTR);
        end
        s_pc  = bus_if.o_pc;
        s_vld = bus_if.o_instr_vld;
        if (bus_if.o_instr_vld === 1'b1 && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (cyc == 2) pc_at_c2 = bus_if.o_pc;
        if (bus_if.o_instr_vld === 1'b1 && bus_if.o_pc === 32'h10C) seen_10c = 1'b1;

        pop    = vld_e && !stall && !sel;
        accept = rv && !sel && !stale;
        if (sel || m_fault)  req_e = 1'b0;
        else if (!outst)     req_e = (sz < DEPTH);
        else if (accept)     req_e = ((sz + 1 - (pop ? 1 : 0)) < DEPTH);
        else                 req_e = 1'b0;
        check1("imem_req", bus_if.o_imem_req, req_e);
        if (req_e) check32("imem_addr", bus_if.o_imem_addr, m_pc);
`ifdef FETCH_MISALIGN_CHK_EN
        check1("fetch_fault", fault_o, m_fault);
        s_fault = fault_o;
`endif

        if (sel) begin
            exp_q.delete();
            if (outst && !rv) stale = 1'b1;
`ifdef FETCH_MISALIGN_CHK_EN
            m_pc    = alu;
            m_fault = (alu[1:0] != 2'b00);
`else
            m_pc = alu & 32'hFFFF_FFFC;
`endif
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (accept) exp_q.push_back('{pc: out_addr, instr: instr_of(out_addr)});
        end
        if (req_e) m_pc = m_pc + 32'd4;

        if (rv) outst = 1'b0;
        if (bus_if.o_imem_req === 1'b1) begin
            check1("single_outstanding", outst, 1'b0);
            outst    = 1'b1;
            stale    = 1'b0;
            out_addr = bus_if.o_imem_addr;
            due      = cyc + lat;
            req_log.push_back(bus_if.o_imem_addr);
            req_cyc.push_back(cyc);
        end
    endtask

    task automatic step(input bit stall, input bit sel, input logic [31:0] alu);
        bit rv;
        rv = outst && (cyc == due);
        bus_if.i_stall       = stall;
        bus_if.i_pc_sel      = sel;
        bus_if.i_alu_data    = alu;
        bus_if.i_imem_rvalid = rv;
        bus_if.i_imem_rdata  = rv ? instr_of(out_addr) : 32'hDEAD_BEEF;
        @(negedge clk);
        compare_cycle(stall, sel, alu, rv);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n                = 1'b0;
        bus_if.i_stall       = 1'b0;
        bus_if.i_pc_sel      = 1'b0;
        bus_if.i_alu_data    = 32'h0;
        bus_if.i_imem_rvalid = 1'b0;
        bus_if.i_imem_rdata  = 32'h0;
        @(negedge clk);
        check1("rst_instr_vld", bus_if.o_instr_vld, 1'b0);
        check32("rst_o_instr", bus_if.o_instr, NOP_INSTR);
        check32("rst_o_pc", bus_if.o_pc, 32'h0);
        check1("rst_imem_req", bus_if.o_imem_req, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        exp_q.delete();
        req_log.delete();
        req_cyc.delete();
        m_pc          = RPC;
        m_fault       = 1'b0;
        outst         = 1'b0;
        stale         = 1'b0;
        first_vld_cyc = -1;
        pc_at_c2      = 32'hX;
        seen_10c      = 1'b0;
    endtask

    initial begin
        int n, nr, rc;
        logic [31:0] pc_a;

        // straight-line fetch, 1-cycle memory
        lat = 1;
        do_reset();
        repeat (8) step(0, 0, 32'h0);
        check32("first_req", req_log[0], 32'h100);
        check32("second_req", req_log[1], 32'h104);
        check32("third_req", req_log[2], 32'h108);
        check32("first_req_cycle", 32'(req_cyc[0]), 32'd0);
        check32("first_vld_cycle", 32'(first_vld_cyc), 32'd2);
        check32("pc_at_cycle2", pc_at_c2, 32'h100);

        // stall with full FIFO, then release
        repeat (2) step(1, 0, 32'h0);
        n    = req_log.size();
        pc_a = s_pc;
        repeat (4) step(1, 0, 32'h0);
        check32("stall_no_req", 32'(req_log.size()), 32'(n));
        check32("stall_pc_stable", s_pc, pc_a);
        rc = cyc;
        step(0, 0, 32'h0);
        step(0, 0, 32'h0);
        check32("resume_req_cycle", 32'(req_cyc[req_cyc.size()-1]), 32'(rc + 1));

        // redirect while 0x10C is outstanding, 3-cycle memory
        lat = 3;
        do_reset();
        n = 0;
        while (!(req_log.size() > 0 && req_log[req_log.size()-1] == 32'h10C) && n < 60) begin
            step(0, 0, 32'h0);
            n++;
        end
        if (n >= 60) begin
            errors++;
            $display("FAIL wait_req_10c: got timeout expected request to 0x10C");
        end
        step(0, 0, 32'h0);
        nr = req_log.size();
        step(0, 1, 32'h200);
        step(0, 0, 32'h0);
        check1("vld_after_redirect", s_vld, 1'b0);
        repeat (8) step(0, 0, 32'h0);
        check32("req_after_redirect", req_log[nr], 32'h200);
        check1("dropped_10c", seen_10c, 1'b0);

        // redirect coinciding with a response, 2-cycle memory
        lat = 2;
        n   = 0;
        while (!(outst && !stale && cyc == due) && n < 40) begin
            step(0, 0, 32'h0);
            n++;
        end
        if (n >= 40) begin
            errors++;
            $display("FAIL wait_rvalid: got timeout expected a live response");
        end
        nr = req_log.size();
        rc = cyc;
        step(0, 1, 32'h400);
        step(0, 0, 32'h0);
        check32("same_cycle_redirect_addr", req_log[nr], 32'h400);
        check32("same_cycle_redirect_cycle", 32'(req_cyc[nr]), 32'(rc + 1));

        // PC wrap-around
        repeat (3) step(0, 0, 32'h0);
        nr = req_log.size();
        step(0, 1, 32'hFFFF_FFFC);
        repeat (10) step(0, 0, 32'h0);
        check32("wrap_first", req_log[nr], 32'hFFFF_FFFC);
        check32("wrap_second", req_log[nr+1], 32'h0000_0000);

`ifdef FETCH_MISALIGN_CHK_EN
        // misaligned redirect faults until an aligned redirect
        step(0, 1, 32'h202);
        n = req_log.size();
        repeat (6) step(0, 0, 32'h0);
        check1("fault_set", s_fault, 1'b1);
        check32("fault_no_req", 32'(req_log.size()), 32'(n));
        nr = req_log.size();
        step(0, 1, 32'h300);
        repeat (6) step(0, 0, 32'h0);
        check1("fault_clear", s_fault, 1'b0);
        check32("fault_resume_addr", req_log[nr], 32'h300);
`else
        // misaligned target is word-aligned
        nr = req_log.size();
        step(0, 1, 32'h202);
        repeat (8) step(0, 0, 32'h0);
        check32("aligned_target", req_log[nr], 32'h200);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of stimulus");
        $fatal(1, "watchdog");
    end

endmodule
